spell_rambus_arbiter: RTL

Two-port arbiter sharing the single OpenRAM wishbone port (rambus) between the spell core's memory unit (port 0) and the host wishbone slave path (port 1). It grants one whole transaction at a time with round-robin fairness, muxes the granted requester onto the RAM bus, and routes ack/data back. An optional watchdog terminates transactions the RAM never acknowledges.

---
 rtl/spell_rambus_arbiter_pkg.sv | 20 ++
 rtl/spell_rambus_arbiter_rr_pick.sv | 21 ++
 rtl/spell_rambus_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spell_rambus_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spell_pkg: shared state encoding and port indices for the rambus arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
package spell_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spell_rambus_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spell_rr_pick: 2-way combinational round-robin selector.
// Rev 1.0
// ---------------------------------------------------------------------------
module spell_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the port that did not own the bus last time wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spell_rambus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spell_rambus_arbiter: shares the OpenRAM wishbone port between core and host.
// Optional watchdog abort enabled by SPELL_ARB_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module spell_rambus_arbiter
  import spell_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset_n,

  input  logic                c0_cyc_i,
  input  logic                c0_stb_i,
  input  logic                c0_we_i,
  input  logic [DATA_W/8-1:0] c0_sel_i,
  input  logic [ADDR_W-1:0]   c0_addr_i,
  input  logic [DATA_W-1:0]   c0_dat_i,
  output logic                c0_ack_o,
  output logic                c0_err_o,
  output logic [DATA_W-1:0]   c0_dat_o,

  input  logic                c1_cyc_i,
  input  logic                c1_stb_i,
  input  logic                c1_we_i,
  input  logic [DATA_W/8-1:0] c1_sel_i,
  input  logic [ADDR_W-1:0]   c1_addr_i,
  input  logic [DATA_W-1:0]   c1_dat_i,
  output logic                c1_ack_o,
  output logic                c1_err_o,
  output logic [DATA_W-1:0]   c1_dat_o,

  output logic                ram_cyc_o,
  output logic                ram_stb_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_sel_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_dat_o,
  input  logic                ram_ack_i,
  input  logic [DATA_W-1:0]   ram_dat_i,

  output logic [1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;

  logic [1:0] req;
  logic [1:0] pick;
  logic       busy;
  logic       owner_cyc;
  logic       done_ack;
  logic       done_to;

  assign req = {c1_cyc_i & c1_stb_i, c0_cyc_i & c0_stb_i};

  spell_rr_pick u_rr_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  // Gating with reset_n drops every output the instant reset asserts.
  assign busy      = (state_q == BUSY) & reset_n;
  assign owner_cyc = (owner_q == PORT_HOST) ? c1_cyc_i : c0_cyc_i;
  assign done_ack  = busy & ram_ack_i;

`ifdef SPELL_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ack and requester abort both take precedence over the watchdog.
  assign done_to = busy & ~ram_ack_i & owner_cyc & (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Watchdog absent: the parameter is kept only so both builds share one interface.
  assign done_to = busy & (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          owner_d = (pick == 2'b10) ? PORT_HOST : PORT_CORE;
        end
      end
      BUSY: begin
        if (ram_ack_i || !owner_cyc || done_to) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= PORT_CORE;
      last_grant_q <= PORT_HOST;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign grant_o[PORT_CORE] = busy & (owner_q == PORT_CORE);
  assign grant_o[PORT_HOST] = busy & (owner_q == PORT_HOST);

  assign ram_cyc_o  = busy;
  assign ram_stb_o  = busy;
  assign ram_we_o   = busy & ((owner_q == PORT_HOST) ? c1_we_i : c0_we_i);
  assign ram_sel_o  = {SEL_W{busy}}  & ((owner_q == PORT_HOST) ? c1_sel_i  : c0_sel_i);
  assign ram_addr_o = {ADDR_W{busy}} & ((owner_q == PORT_HOST) ? c1_addr_i : c0_addr_i);
  assign ram_dat_o  = {DATA_W{busy}} & ((owner_q == PORT_HOST) ? c1_dat_i  : c0_dat_i);

  assign c0_ack_o = done_ack & (owner_q == PORT_CORE);
  assign c1_ack_o = done_ack & (owner_q == PORT_HOST);
  assign c0_err_o = done_to  & (owner_q == PORT_CORE);
  assign c1_err_o = done_to  & (owner_q == PORT_HOST);

  assign c0_dat_o = ram_dat_i;
  assign c1_dat_o = ram_dat_i;

endmodule
`default_nettype wire
